// File: rtl/spi_byte_engine_pkg.sv
// Shared constants for the SPI byte engine and the peripheral that instantiates it.
package spi_byte_engine_pkg;

    typedef enum logic [1:0] {
        SPI_IDLE  = 2'd0,
        SPI_SHIFT = 2'd1,
        SPI_DONE  = 2'd2
    } spi_state_e;

    localparam int SPI_BYTE_BITS = 8;

endpackage

// File: rtl/spi_byte_engine.sv
// Mode-0 MSB-first SPI master shifter: pops a TX byte, exchanges it on mosi/miso,
// pushes the received byte. Starts only with RX space available, so pushes never stall.
module spi_byte_engine
    import spi_byte_engine_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SPI_BYTE_BITS-1:0] din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [SPI_BYTE_BITS-1:0] dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     busy,
    output logic                     sck,
    output logic                     mosi,
    input  logic                     miso
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [2:0]       BIT_LAST = 3'(SPI_BYTE_BITS - 1);

    spi_state_e               state;
    logic [DIV_W-1:0]         div_cnt;
    logic [2:0]               bit_cnt;
    logic [SPI_BYTE_BITS-1:0] tx_sr;
    logic [SPI_BYTE_BITS-1:0] rx_sr;
    logic                     div_tc;

    assign din_ready = (state == SPI_IDLE) && din_valid && dout_ready;
    assign div_tc    = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SPI_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            sck        <= 1'b0;
            mosi       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            case (state)
                SPI_IDLE: begin
                    if (din_ready) begin
                        tx_sr   <= din;
                        mosi    <= din[SPI_BYTE_BITS-1];
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= SPI_SHIFT;
                    end
                end
                SPI_SHIFT: begin
                    if (!div_tc) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                        if (!sck) begin
                            // Rising SCK: sample miso on the same clk edge.
                            rx_sr <= {rx_sr[SPI_BYTE_BITS-2:0], miso};
                        end else if (bit_cnt == BIT_LAST) begin
                            // Last falling edge: mosi keeps bit 0, result goes out next cycle.
                            dout       <= rx_sr;
                            dout_valid <= 1'b1;
                            state      <= SPI_DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_sr   <= {tx_sr[SPI_BYTE_BITS-2:0], 1'b0};
                            mosi    <= tx_sr[SPI_BYTE_BITS-2];
                        end
                    end
                end
                SPI_DONE: begin
                    busy  <= 1'b0;
                    state <= SPI_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    sck   <= 1'b0;
                    state <= SPI_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Bench for spi_byte_engine: two instances (CLK_DIV 2 and 1) checked every cycle
// against a cycle-count model of one byte exchange, plus literal scenario checks.
module tb_spi_byte_engine;

    localparam int CD0 = 2;
    localparam int CD1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0][7:0] din;
    logic [1:0]      din_valid;
    logic [1:0]      dout_ready;
    logic [1:0]      miso;
    logic [1:0]      miso_drv;
    int              miso_mode [2];  // 0/1 tied, 2 loopback, 3 random

    logic [1:0]      din_ready_w;
    logic [1:0][7:0] dout_w;
    logic [1:0]      dout_valid_w;
    logic [1:0]      busy_w;
    logic [1:0]      sck_w;
    logic [1:0]      mosi_w;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    always_comb begin
        miso = '0;
        for (int i = 0; i < 2; i++)
            miso[i] = (miso_mode[i] == 2) ? mosi_w[i] : miso_drv[i];
    end

    spi_byte_engine #(.CLK_DIV(CD0)) u_dut0 (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready_w[0]),
        .dout(dout_w[0]), .dout_valid(dout_valid_w[0]), .dout_ready(dout_ready[0]),
        .busy(busy_w[0]), .sck(sck_w[0]), .mosi(mosi_w[0]), .miso(miso[0])
    );

    spi_byte_engine #(.CLK_DIV(CD1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready_w[1]),
        .dout(dout_w[1]), .dout_valid(dout_valid_w[1]), .dout_ready(dout_ready[1]),
        .busy(busy_w[1]), .sck(sck_w[1]), .mosi(mosi_w[1]), .miso(miso[1])
    );

    // TX FIFO contents per instance
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    bit         popn [2];

    // Model: k = cycles since the pop (0 = idle), byte, received bits, last result
    int         k      [2];
    logic [7:0] mbyte  [2];
    logic [7:0] mrx    [2];
    logic [7:0] mdout  [2];
    logic       mlast  [2];

    // Observations for scenario checks
    int         rdy_cnt [2];
    int         rise_cnt[2];
    int         busy_cnt[2];
    int         dv_cnt  [2];
    int         rdy_cyc [2];
    int         dv_cyc  [2];
    logic       mosi_or [2];
    logic       psck    [2];
    logic [7:0] rx0 [$];
    logic [7:0] rx1 [$];
    int         rdyc1 [$];

    function automatic int cd(input int i);
        return (i == 0) ? CD0 : CD1;
    endfunction

    task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cyc=%0d actual=%h expected=%h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    int         c_v, idx_v;
    logic       e_rdy, e_busy, e_sck, e_mosi, e_dv, m_bit;
    logic [7:0] e_dout;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            c_v    = cd(i);
            e_dout = mdout[i];
            e_rdy  = 1'b0;
            e_busy = 1'b0;
            e_sck  = 1'b0;
            e_mosi = mlast[i];
            e_dv   = 1'b0;
            if (rst) begin
                k[i] = 0; mlast[i] = 1'b0; mdout[i] = 8'h00;
                e_dout = 8'h00;
                e_mosi = 1'b0;
                e_rdy  = din_valid[i] & dout_ready[i];
            end else if (k[i] == 0) begin
                e_rdy = din_valid[i] & dout_ready[i];
            end else if (k[i] <= 16 * c_v) begin
                e_busy = 1'b1;
                e_sck  = (((k[i] - 1) / c_v) % 2) == 1;
                idx_v  = (k[i] - 1) / (2 * c_v);
                if (idx_v > 7) idx_v = 7;
                e_mosi = mbyte[i][7 - idx_v];
            end else begin
                e_busy = 1'b1;
                e_mosi = mbyte[i][0];
                e_dv   = 1'b1;
                e_dout = mrx[i];
            end
            chk("din_ready",  i, 8'(din_ready_w[i]),  8'(e_rdy));
            chk("busy",       i, 8'(busy_w[i]),       8'(e_busy));
            chk("sck",        i, 8'(sck_w[i]),        8'(e_sck));
            chk("mosi",       i, 8'(mosi_w[i]),       8'(e_mosi));
            chk("dout_valid", i, 8'(dout_valid_w[i]), 8'(e_dv));
            chk("dout",       i, dout_w[i],           e_dout);

            if (!rst) begin
                if (k[i] == 0) begin
                    if (e_rdy) begin
                        mbyte[i] = din[i]; mrx[i] = 8'h00; k[i] = 1; popn[i] = 1'b1;
                    end
                end else if (k[i] <= 16 * c_v) begin
                    if (k[i] % (2 * c_v) == c_v) begin
                        m_bit  = (miso_mode[i] == 2) ? e_mosi : miso_drv[i];
                        mrx[i] = {mrx[i][6:0], m_bit};
                    end
                    k[i]++;
                end else begin
                    mdout[i] = mrx[i];
                    mlast[i] = mbyte[i][0];
                    k[i]     = 0;
                end

                if (din_ready_w[i]) begin
                    rdy_cnt[i]++; rdy_cyc[i] = cyc;
                    if (i == 1) rdyc1.push_back(cyc);
                end
                if (busy_w[i]) busy_cnt[i]++;
                if (sck_w[i] && !psck[i]) begin
                    rise_cnt[i]++; mosi_or[i] = mosi_or[i] | mosi_w[i];
                end
                if (dout_valid_w[i]) begin
                    dv_cnt[i]++; dv_cyc[i] = cyc;
                    if (i == 0) rx0.push_back(dout_w[i]); else rx1.push_back(dout_w[i]);
                end
            end
            psck[i] = sck_w[i];
        end
        cyc++;
    end

    // FIFO head / miso driver, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        if (popn[0]) begin q0.delete(0); popn[0] = 1'b0; end
        if (popn[1]) begin q1.delete(0); popn[1] = 1'b0; end
        din[0]       = (q0.size() != 0) ? q0[0] : 8'h00;
        din_valid[0] = (q0.size() != 0);
        din[1]       = (q1.size() != 0) ? q1[0] : 8'h00;
        din_valid[1] = (q1.size() != 0);
        for (int i = 0; i < 2; i++)
            if (miso_mode[i] == 3) miso_drv[i] = 1'($urandom);
    end

    task automatic clear_stats(input int i);
        rdy_cnt[i] = 0; rise_cnt[i] = 0; busy_cnt[i] = 0; dv_cnt[i] = 0;
        rdy_cyc[i] = 0; dv_cyc[i] = 0; mosi_or[i] = 1'b0;
        if (i == 0) rx0.delete(); else begin rx1.delete(); rdyc1.delete(); end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        if (i == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    task automatic wait_idle(input int i, input int budget);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk); #1;
            n++;
            done = ((i == 0) ? q0.size() : q1.size()) == 0 && k[i] == 0 && !popn[i];
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_idle[%0d] timed out after %0d cycles", i, budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        din        = '0;
        din_valid  = '0;
        dout_ready = 2'b11;
        miso_drv   = '0;
        miso_mode  = '{2, 2};
        for (int i = 0; i < 2; i++) begin
            mlast[i] = 1'b0; mdout[i] = 8'h00; psck[i] = 1'b0; clear_stats(i);
        end
        repeat (3) @(negedge clk);
        lit("reset_dout0", int'(dout_w[0]), 0);
        lit("reset_busy0", int'(busy_w[0]), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Loopback 0xA5 at CLK_DIV=2
        clear_stats(0);
        push(0, 8'hA5);
        wait_idle(0, 200);
        lit("a5_ready_pulses", rdy_cnt[0], 1);
        lit("a5_sck_rises", rise_cnt[0], 8);
        lit("a5_rx_count", rx0.size(), 1);
        lit("a5_dout", (rx0.size() != 0) ? int'(rx0[0]) : -1, 8'hA5);
        lit("a5_latency", dv_cyc[0] - rdy_cyc[0], 16 * CD0 + 1);
        lit("a5_busy_cycles", busy_cnt[0], 16 * CD0 + 1);

        // miso tied high / low
        clear_stats(0);
        miso_mode[0] = 1; miso_drv[0] = 1'b1;
        push(0, 8'h00);
        wait_idle(0, 200);
        lit("zero_mosi_at_rises", int'(mosi_or[0]), 0);
        lit("ones_dout", (rx0.size() != 0) ? int'(rx0[0]) : -1, 8'hFF);
        clear_stats(0);
        miso_mode[0] = 0; miso_drv[0] = 1'b0;
        push(0, 8'hFF);
        wait_idle(0, 200);
        lit("zeros_dout", (rx0.size() != 0) ? int'(rx0[0]) : -1, 8'h00);

        // RX full holds off the start
        clear_stats(0);
        miso_mode[0] = 2;
        @(posedge clk); #1 dout_ready[0] = 1'b0;
        push(0, 8'h77);
        repeat (20) @(negedge clk);
        lit("bp_no_ready", rdy_cnt[0], 0);
        lit("bp_no_busy", busy_cnt[0], 0);
        lit("bp_no_sck", rise_cnt[0], 0);
        @(posedge clk); #1 dout_ready[0] = 1'b1;
        #1 lit("bp_ready_same_cycle", int'(din_ready_w[0]), 1);
        wait_idle(0, 200);
        lit("bp_dout", (rx0.size() != 0) ? int'(rx0[0]) : -1, 8'h77);

        // Random bytes, random miso, random RX backpressure
        clear_stats(0);
        miso_mode[0] = 3;
        for (int j = 0; j < 6; j++) push(0, 8'($urandom));
        n = 0;
        while (!(q0.size() == 0 && k[0] == 0 && !popn[0]) && n < 3000) begin
            @(posedge clk); #2 dout_ready[0] = ($urandom_range(0, 3) != 0);
            n++;
        end
        dout_ready[0] = 1'b1;
        wait_idle(0, 200);
        lit("rand_byte_count", dv_cnt[0], 6);

        // Three queued bytes back to back at CLK_DIV=1
        clear_stats(1);
        push(1, 8'h12); push(1, 8'h34); push(1, 8'h56);
        wait_idle(1, 300);
        lit("b2b_count", rx1.size(), 3);
        if (rx1.size() == 3 && rdyc1.size() == 3) begin
            lit("b2b_byte0", int'(rx1[0]), 8'h12);
            lit("b2b_byte1", int'(rx1[1]), 8'h34);
            lit("b2b_byte2", int'(rx1[2]), 8'h56);
            lit("b2b_period01", rdyc1[1] - rdyc1[0], 18);
            lit("b2b_period12", rdyc1[2] - rdyc1[1], 18);
        end
        lit("b2b_latency", dv_cyc[1] - rdy_cyc[1], 17);
        lit("b2b_rises", rise_cnt[1], 24);

        // Reset after the third rising edge aborts the byte
        clear_stats(0);
        miso_mode[0] = 2;
        push(0, 8'hE7);
        n = 0;
        while (rise_cnt[0] < 3 && n < 200) begin @(negedge clk); #1 n++; end
        lit("rst_reached_third_rise", rise_cnt[0], 3);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        lit("rst_sck", int'(sck_w[0]), 0);
        lit("rst_mosi", int'(mosi_w[0]), 0);
        lit("rst_busy", int'(busy_w[0]), 0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        lit("rst_no_dout_valid", dv_cnt[0], 0);
        push(0, 8'h3C);
        wait_idle(0, 200);
        lit("rst_next_count", rx0.size(), 1);
        lit("rst_next_dout", (rx0.size() != 0) ? int'(rx0[0]) : -1, 8'h3C);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
